// File: rtl/pipe_reg_file.sv
// Three-port register file with a pending-write scoreboard for in-order issue.
// Register 0 is hardwired to zero and can never become pending.
module pipe_reg_file #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WE3,
  input  logic [AW-1:0]   WR3,
  input  logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   RR1,
  input  logic [AW-1:0]   RR2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            ISS,
  input  logic [AW-1:0]   ISS_RD,
  output logic            BUSY1,
  output logic            BUSY2,
  output logic [AW:0]     PEND_CNT
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic [AW:0]     pend_cnt;

  logic wr_valid;
  logic iss_valid;
  logic fwd1;
  logic fwd2;
  logic set_new;
  logic clr_old;

  assign wr_valid  = WE3 && (WR3 != '0);
  assign iss_valid = ISS && (ISS_RD != '0);
  assign fwd1      = BYP && wr_valid && (WR3 == RR1);
  assign fwd2      = BYP && wr_valid && (WR3 == RR2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[WR3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RR1 != '0) begin
      RD1 = regs[RR1];
    end
    if (RR2 != '0) begin
      RD2 = regs[RR2];
    end
    if (fwd1) begin
      RD1 = WD3;
    end
    if (fwd2) begin
      RD2 = WD3;
    end
  end

  // Set is applied after clear so a same-index issue and writeback leaves the bit pending.
  always_comb begin
    pending_next = pending;
    if (wr_valid) begin
      pending_next[WR3] = 1'b0;
    end
    if (iss_valid) begin
      pending_next[ISS_RD] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Count tracks only real bit transitions, so it always equals popcount(pending).
  assign set_new = iss_valid && !pending[ISS_RD];
  assign clr_old = wr_valid && pending[WR3] && !(iss_valid && (ISS_RD == WR3));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_cnt <= '0;
    end else begin
      case ({set_new, clr_old})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  assign PEND_CNT = pend_cnt;
  assign BUSY1    = pending[RR1] && !fwd1;
  assign BUSY2    = pending[RR2] && !fwd2;

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file: one forwarding and one non-forwarding instance
// share the same stimulus and are checked against hand-computed values.
module tb_pipe_reg_file;

  logic        CLK;
  logic        RST;
  logic        WE3;
  logic [4:0]  WR3;
  logic [31:0] WD3;
  logic [4:0]  RR1;
  logic [4:0]  RR2;
  logic        ISS;
  logic [4:0]  ISS_RD;

  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy1;
  logic        busy2;
  logic [5:0]  pend_cnt;
  logic [31:0] rd1_nb;
  logic [31:0] rd2_nb;
  logic        busy1_nb;
  logic        busy2_nb;
  logic [5:0]  pend_cnt_nb;

  int vectors;
  int miscompares;

  pipe_reg_file #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .WE3(WE3), .WR3(WR3), .WD3(WD3),
    .RR1(RR1), .RR2(RR2), .RD1(rd1), .RD2(rd2),
    .ISS(ISS), .ISS_RD(ISS_RD), .BUSY1(busy1), .BUSY2(busy2),
    .PEND_CNT(pend_cnt)
  );

  pipe_reg_file #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .WE3(WE3), .WR3(WR3), .WD3(WD3),
    .RR1(RR1), .RR2(RR2), .RD1(rd1_nb), .RD2(rd2_nb),
    .ISS(ISS), .ISS_RD(ISS_RD), .BUSY1(busy1_nb), .BUSY2(busy2_nb),
    .PEND_CNT(pend_cnt_nb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic iss, input logic [4:0] iss_rd);
    WE3 = we;
    WR3 = wr;
    WD3 = wd;
    RR1 = r1;
    RR2 = r2;
    ISS = iss;
    ISS_RD = iss_rd;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    RST = 1'b1;
    #1;

    // Reset state across every index
    checkOutput("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
      checkOutput("rst_rd1", rd1, 32'd0);
      checkOutput("rst_rd2", rd2, 32'd0);
      checkOutput("rst_busy", 32'({busy1, busy2, busy1_nb, busy2_nb}), 32'd0);
    end
    tick();
    RST = 1'b0;
    tick();

    // Forwarding vs. non-forwarding write of r5
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
    checkOutput("byp_rd1_same_cycle", rd1, 32'hDEADBEEF);
    checkOutput("nobyp_rd1_same_cycle", rd1_nb, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
    checkOutput("byp_rd1_after", rd1, 32'hDEADBEEF);
    checkOutput("nobyp_rd1_after", rd1_nb, 32'hDEADBEEF);

    // Issue r7, then write it back
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b1, 5'd7);
    checkOutput("iss_busy2_same_cycle", 32'(busy2), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0);
    checkOutput("iss_busy2", 32'(busy2), 32'd1);
    checkOutput("iss_busy2_nb", 32'(busy2_nb), 32'd1);
    checkOutput("iss_pend_cnt", 32'(pend_cnt), 32'd1);
    applyStimulus(1'b1, 5'd7, 32'h12, 5'd0, 5'd7, 1'b0, 5'd0);
    checkOutput("wb_busy2_byp", 32'(busy2), 32'd0);
    checkOutput("wb_busy2_nobyp", 32'(busy2_nb), 32'd1);
    checkOutput("wb_rd2_byp", rd2, 32'h12);
    checkOutput("wb_pend_cnt_before", 32'(pend_cnt), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0);
    checkOutput("wb_pend_cnt", 32'(pend_cnt), 32'd0);
    checkOutput("wb_pend_cnt_nb", 32'(pend_cnt_nb), 32'd0);
    checkOutput("wb_busy2_after", 32'(busy2_nb), 32'd0);
    checkOutput("wb_rd2_after", rd2_nb, 32'h12);

    // Same-cycle issue and write to r9: set wins, data still written
    applyStimulus(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b1, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 5'd0);
    checkOutput("same_rd1", rd1, 32'h55);
    checkOutput("same_busy1", 32'(busy1), 32'd1);
    checkOutput("same_pend_cnt", 32'(pend_cnt), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 5'd0);
    checkOutput("reiss_pend_cnt", 32'(pend_cnt), 32'd1);
    checkOutput("reiss_busy1", 32'(busy1), 32'd1);
    applyStimulus(1'b1, 5'd9, 32'h66, 5'd9, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 5'd0);
    checkOutput("single_wb_pend_cnt", 32'(pend_cnt), 32'd0);
    checkOutput("single_wb_busy1", 32'(busy1), 32'd0);
    checkOutput("single_wb_rd1", rd1, 32'h66);

    // Set and clear on different bits in one edge: net zero
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd10);
    tick();
    applyStimulus(1'b1, 5'd10, 32'hA0, 5'd0, 5'd0, 1'b1, 5'd11);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("swap_pend_cnt", 32'(pend_cnt), 32'd1);
    checkOutput("swap_busy1_r10", 32'(busy1), 32'd0);
    checkOutput("swap_busy2_r11", 32'(busy2), 32'd1);
    applyStimulus(1'b1, 5'd11, 32'hB0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("swap_clear_pend_cnt", 32'(pend_cnt), 32'd0);
    checkOutput("write_nonpending_rd2", rd2, 32'hB0);

    // Register 0 ignores writes and issues
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    checkOutput("r0_rd1_same_cycle", rd1, 32'd0);
    checkOutput("r0_busy1", 32'(busy1), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("r0_rd1", rd1, 32'd0);
    checkOutput("r0_pend_cnt", 32'(pend_cnt), 32'd0);

    // Fill the scoreboard to its ceiling, then reset mid-cycle
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b1, 5'(i));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 1'b1, 5'd31);
    checkOutput("full_pend_cnt", 32'(pend_cnt), 32'd31);
    checkOutput("full_busy2", 32'(busy2), 32'd1);
    checkOutput("full_rd1", rd1, 32'hA5A5A5A5);
    tick();
    checkOutput("full_reiss_pend_cnt", 32'(pend_cnt), 32'd31);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_pend_cnt", 32'(pend_cnt), 32'd0);
    checkOutput("async_rst_rd1_r3", rd1, 32'd0);
    checkOutput("async_rst_busy2", 32'(busy2), 32'd0);
    applyStimulus(1'b1, 5'd4, 32'hCAFEF00D, 5'd5, 5'd4, 1'b1, 5'd4);
    checkOutput("rst_byp_rd2", rd2, 32'hCAFEF00D);
    checkOutput("rst_nobyp_rd2", rd2_nb, 32'd0);
    checkOutput("rst_rd1_r5", rd1, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd0);
    checkOutput("rst_write_ignored", rd1, 32'd0);
    checkOutput("rst_issue_ignored", 32'(pend_cnt), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    RST = 1'b0;
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd0);
    checkOutput("post_rst_pend_cnt", 32'(pend_cnt), 32'd1);
    checkOutput("post_rst_busy1", 32'(busy1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- XLEN, 32, data width.
- NREG, 32, register count, power of 2, >=2.
- BYPASS, 1, 1 = write-to-read forwarding enabled.
- AW, log2(NREG), derived index width; not overridden.

REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK, in, 1, clock; all state updates on rising edge.
- RST, in, 1, reset, asynchronous, active-high.
- WE3, in, 1, write enable.
- WR3, in, AW, write index.
- WD3, in, XLEN, write data.
- RR1, in, AW, read index, port 1.
- RR2, in, AW, read index, port 2.
- RD1, out, XLEN, read data, port 1.
- RD2, out, XLEN, read data, port 2.
- ISS, in, 1, issue strobe: an instruction targeting ISS_RD has been issued.
- ISS_RD, in, AW, destination index of the issued instruction.
- BUSY1, out, 1, port 1 operand not yet available.
- BUSY2, out, 1, port 2 operand not yet available.
- PEND_CNT, out, AW+1, number of registers with a pending write.

Function
REQ-003 SHALL hold NREG x XLEN data registers plus an NREG-bit pending vector.
REQ-004 Register 0 SHALL read as zero; writes to it ignored; its pending bit never set.
REQ-005 Write: on posedge with WE3=1 and WR3!=0, Regs[WR3] <= WD3.
REQ-006 Reads SHALL be combinational with zero latency: RDn = Regs[RRn].
REQ-007 If BYPASS=1, WE3=1, WR3!=0 and WR3==RRn, RDn SHALL equal WD3 in the same cycle.
REQ-008 If BYPASS=0, RDn SHALL show the old value until the edge after the write.
REQ-009 ISS=1 and ISS_RD!=0 SHALL set pending[ISS_RD] on the next posedge.
REQ-010 WE3=1 and WR3!=0 SHALL clear pending[WR3] on the next posedge.
REQ-011 When ISS and WE3 target the same nonzero index in one cycle, set SHALL win: pending=1, data written.
REQ-012 Issue to an already-pending register SHALL leave it pending; a single subsequent write clears it.
REQ-013 Write to a non-pending register SHALL update data; pending stays 0.
REQ-014 BUSYn SHALL be combinational: pending[RRn] & ~(BYPASS & WE3 & WR3==RRn & WR3!=0).
REQ-015 BUSYn SHALL be 0 when RRn==0.
REQ-016 ISS in the current cycle SHALL NOT affect BUSYn until the next cycle.
REQ-017 PEND_CNT SHALL be a registered count equal to popcount(pending) after every edge.
REQ-018 PEND_CNT update rule per edge:
- +1 for a set of a previously clear bit.
- -1 for a clear of a set bit.
- Net 0 when both occur on different bits.
REQ-019 PEND_CNT SHALL range 0..NREG-1 and never wrap.

Reset
REQ-020 RST=1 SHALL immediately, without waiting for CLK:
- clear all data registers to 0;
- clear all pending bits;
- set PEND_CNT=0.
REQ-021 While RST=1, writes and issues SHALL be ignored.
REQ-022 While RST=1, outputs SHALL be RD1=RD2=0, BUSY1=BUSY2=0, PEND_CNT=0; exception: when BYPASS=1 and a write is presented, RDn follows REQ-007 combinationally.
REQ-023 Deassertion of RST SHALL take effect at the first following posedge; reset asserted mid-operation discards all pending state.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read all indices: RD=0, BUSY=0, PEND_CNT=0.
- WE3=1, WR3=5, WD3=0xDEADBEEF, RR1=5, BYPASS=1: RD1=0xDEADBEEF in the same cycle; with BYPASS=0, only after the edge.
- ISS, ISS_RD=7; next cycle RR2=7: BUSY2=1, PEND_CNT=1. Then write r7=0x12: BUSY2=0 in the write cycle (BYPASS=1), PEND_CNT=0 after the edge.
- Same-cycle ISS_RD=9 and WR3=9, WD3=0x55: r9=0x55, pending[9]=1, PEND_CNT increments by 1.
- Write r0=0xFFFFFFFF and ISS_RD=0: RD1(r0)=0, PEND_CNT unchanged.
- Issue r1..r31, then assert RST mid-sequence asynchronously: PEND_CNT=0 and r3=0 before the next edge.
